ddr3_wr_burst_ctrl: RTL and testbench

//  Downstream of the test-data generator's write FIFO (FWFT, 256-bit). On wr_start it waits for a full burst in the FIFO.
//  It then drains BURST_LEN words into the MIG user interface as write commands with data.
//  The address advances linearly and wraps at ADDR_MAX. Its fifo_rd_en is the data_req that paces the generator.

---
 rtl/ddr3_wr_burst_ctrl_pkg.sv | 15 +
 rtl/ddr3_wr_burst_ctrl.sv | 105 ++++++++++
 tb/tb_ddr3_wr_burst_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_wr_burst_ctrl_pkg.sv
// Shared definitions for the DDR3 write-burst controller: MIG command codes
// and the burst sequencer state encodings.
package ddr3_wr_burst_ctrl_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef logic [1:0] wr_state_t;

   localparam wr_state_t ST_IDLE  = 2'd0;
   localparam wr_state_t ST_WAIT  = 2'd1;
   localparam wr_state_t ST_WRITE = 2'd2;
   localparam wr_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ddr3_wr_burst_ctrl.sv
// Drains one burst of BURST_LEN words from the generator's FWFT FIFO into the
// MIG user interface. Command and data are issued together, one word per beat,
// and the beat address walks linearly, wrapping after ADDR_MAX.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for wr_start
//   WAIT     | burst requested, waiting for a full burst in the FIFO
//   WRITE    | issuing beats whenever app_rdy and app_wdf_rdy are both high
//   DONE     | burst complete, wr_done pulses for this one cycle
module ddr3_wr_burst_ctrl
   import ddr3_wr_burst_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 28,
   parameter int unsigned       DATA_W    = 256,
   parameter int unsigned       CNT_W     = 10,
   parameter int unsigned       BURST_LEN = 64,
   parameter int unsigned       ADDR_STEP = 8,
   parameter logic [ADDR_W-1:0] ADDR_MAX  = 28'h7FFFFF8
)(
   input  logic                ui_clk,
   input  logic                rst,
   input  logic                wr_start,
   input  logic [CNT_W-1:0]    fifo_rd_count,
   input  logic [DATA_W-1:0]   fifo_rd_data,
   output logic                fifo_rd_en,
   input  logic                app_rdy,
   input  logic                app_wdf_rdy,
   output logic                app_en,
   output logic [2:0]          app_cmd,
   output logic [ADDR_W-1:0]   app_addr,
   output logic                app_wdf_wren,
   output logic                app_wdf_end,
   output logic [DATA_W-1:0]   app_wdf_data,
   output logic [DATA_W/8-1:0] app_wdf_mask,
   output logic                wr_busy,
   output logic                wr_done
);

   localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);

   wr_state_t         state_r;
   logic [CNT_W-1:0]  beat_cnt;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_nxt;
   logic              fire;
   logic              last_beat;
   logic              wait_go;

   // A beat needs both MIG interfaces ready in the same cycle so command and
   // data never split; reset suppresses it so an abandoned burst pops nothing.
   assign fire      = (state_r == ST_WRITE) && app_rdy && app_wdf_rdy && !rst;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign wait_go   = (state_r == ST_WAIT) && (fifo_rd_count >= BURST_CNT);
   assign addr_nxt  = (addr_r == ADDR_MAX) ? '0 : addr_r + ADDR_INC;

   // Burst sequencer.
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  if (wr_start)            state_r <= ST_WAIT;
            ST_WAIT:  if (wait_go)             state_r <= ST_WRITE;
            ST_WRITE: if (fire && last_beat)   state_r <= ST_DONE;
            ST_DONE:                           state_r <= ST_IDLE;
            default:                           state_r <= ST_IDLE;
         endcase
      end
   end

   // Beat counter: restarted when the burst begins, advanced per issued beat.
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (wait_go) begin
         beat_cnt <= '0;
      end else if (fire) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

   // Beat address carries over between bursts; only reset returns it to 0.
   always_ff @(posedge ui_clk) begin
      if (rst) begin
         addr_r <= '0;
      end else if (fire) begin
         addr_r <= addr_nxt;
      end
   end

   assign app_en       = fire;
   assign app_wdf_wren = fire;
   assign app_wdf_end  = fire;
   assign fifo_rd_en   = fire;
   assign app_cmd      = CMD_WR;
   assign app_addr     = addr_r;
   assign app_wdf_data = fifo_rd_data;
   assign app_wdf_mask = '0;
   assign wr_busy      = (state_r == ST_WAIT) || (state_r == ST_WRITE);
   assign wr_done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// Directed bench for ddr3_wr_burst_ctrl with a 4-beat burst and a small
// address range (0..40) so the address wrap shows up within a few bursts.
module tb_ddr3_wr_burst_ctrl;

   localparam int unsigned       ADDR_W    = 28;
   localparam int unsigned       DATA_W    = 256;
   localparam int unsigned       CNT_W     = 10;
   localparam int unsigned       BURST_LEN = 4;
   localparam int unsigned       ADDR_STEP = 8;
   localparam logic [ADDR_W-1:0] ADDR_MAX  = 28'd40;

   logic                ui_clk = 1'b0;
   logic                rst;
   logic                wr_start;
   logic [CNT_W-1:0]    fifo_rd_count;
   logic [DATA_W-1:0]   fifo_rd_data;
   logic                fifo_rd_en;
   logic                app_rdy;
   logic                app_wdf_rdy;
   logic                app_en;
   logic [2:0]          app_cmd;
   logic [ADDR_W-1:0]   app_addr;
   logic                app_wdf_wren;
   logic                app_wdf_end;
   logic [DATA_W-1:0]   app_wdf_data;
   logic [DATA_W/8-1:0] app_wdf_mask;
   logic                wr_busy;
   logic                wr_done;

   int checks   = 0;
   int failures = 0;

   always #5 ui_clk = ~ui_clk;

   ddr3_wr_burst_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .BURST_LEN (BURST_LEN),
      .ADDR_STEP (ADDR_STEP),
      .ADDR_MAX  (ADDR_MAX)
   ) dut (
      .ui_clk        (ui_clk),
      .rst           (rst),
      .wr_start      (wr_start),
      .fifo_rd_count (fifo_rd_count),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_en    (fifo_rd_en),
      .app_rdy       (app_rdy),
      .app_wdf_rdy   (app_wdf_rdy),
      .app_en        (app_en),
      .app_cmd       (app_cmd),
      .app_addr      (app_addr),
      .app_wdf_wren  (app_wdf_wren),
      .app_wdf_end   (app_wdf_end),
      .app_wdf_data  (app_wdf_data),
      .app_wdf_mask  (app_wdf_mask),
      .wr_busy       (wr_busy),
      .wr_done       (wr_done)
   );

   typedef struct {
      logic              rst;
      logic              start;
      logic [CNT_W-1:0]  cnt;
      logic              rdy;
      logic              wrdy;
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic              busy;
      logic              done;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic s, input int c, input logic rd, input logic wd,
                      input logic en, input int addr, input logic busy, input logic done);
      vec_t v;
      v.rst   = r;
      v.start = s;
      v.cnt   = CNT_W'(c);
      v.rdy   = rd;
      v.wrdy  = wd;
      v.en    = en;
      v.addr  = ADDR_W'(addr);
      v.busy  = busy;
      v.done  = done;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   // Outputs that must hold in every cycle, given the expected beat strobe.
   task automatic chk_common(input int idx, input logic exp_en);
      chk("fifo_rd_en",   idx, 64'(fifo_rd_en),   64'(exp_en));
      chk("app_wdf_wren", idx, 64'(app_wdf_wren), 64'(exp_en));
      chk("app_wdf_end",  idx, 64'(app_wdf_end),  64'(exp_en));
      chk("app_cmd",      idx, 64'(app_cmd),      64'd0);
      chk("app_wdf_mask", idx, 64'(app_wdf_mask), 64'd0);
      chk("wdf_data",     idx, 64'(app_wdf_data == fifo_rd_data), 64'd1);
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_fire;
      int                fires;
      logic              saw_wrap;

      rst           = 1'b1;
      wr_start      = 1'b0;
      fifo_rd_count = '0;
      fifo_rd_data  = '0;
      app_rdy       = 1'b1;
      app_wdf_rdy   = 1'b1;

      //   rst st cnt rdy wrdy | en addr busy done
      // T1: reset held 5 cycles, then released
      for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 1,  0,  0, 0, 0);
      add(0, 0, 0, 1, 1,  0,  0, 0, 0);
      // T2: full burst, both ready
      add(0, 1, 4, 1, 1,  0,  0, 0, 0);
      add(0, 0, 4, 1, 1,  0,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  8, 1, 0);
      add(0, 0, 4, 1, 1,  1, 16, 1, 0);
      add(0, 0, 4, 1, 1,  1, 24, 1, 0);
      add(0, 0, 0, 1, 1,  0, 32, 0, 1);
      add(0, 0, 0, 1, 1,  0, 32, 0, 0);
      // T3: write-data not ready for 3 cycles on the second beat; wraps after 40
      add(0, 1, 4, 1, 1,  0, 32, 0, 0);
      add(0, 0, 4, 1, 1,  0, 32, 1, 0);
      add(0, 0, 4, 1, 1,  1, 32, 1, 0);
      add(0, 0, 4, 1, 0,  0, 40, 1, 0);
      add(0, 0, 4, 1, 0,  0, 40, 1, 0);
      add(0, 0, 4, 1, 0,  0, 40, 1, 0);
      add(0, 0, 4, 1, 1,  1, 40, 1, 0);
      add(0, 0, 4, 1, 1,  1,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  8, 1, 0);
      add(0, 0, 0, 1, 1,  0, 16, 0, 1);
      // T4: FIFO short of a burst, then filled; command-ready stall; start ignored when busy
      add(0, 1, 2, 1, 1,  0, 16, 0, 0);
      add(0, 0, 2, 1, 1,  0, 16, 1, 0);
      add(0, 1, 2, 1, 1,  0, 16, 1, 0);
      add(0, 0, 3, 1, 1,  0, 16, 1, 0);
      add(0, 0, 4, 1, 1,  0, 16, 1, 0);
      add(0, 0, 4, 1, 1,  1, 16, 1, 0);
      add(0, 0, 4, 0, 1,  0, 24, 1, 0);
      add(0, 0, 4, 1, 1,  1, 24, 1, 0);
      add(0, 1, 4, 1, 1,  1, 32, 1, 0);
      add(0, 0, 4, 1, 1,  1, 40, 1, 0);
      add(0, 1, 0, 1, 1,  0,  0, 0, 1);
      add(0, 0, 4, 1, 1,  0,  0, 0, 0);
      // T6: reset after two beats abandons the burst and clears the address
      add(0, 1, 4, 1, 1,  0,  0, 0, 0);
      add(0, 0, 4, 1, 1,  0,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  8, 1, 0);
      add(1, 0, 4, 1, 1,  0, 16, 1, 0);
      add(0, 0, 4, 1, 1,  0,  0, 0, 0);
      add(0, 1, 4, 1, 1,  0,  0, 0, 0);
      add(0, 0, 4, 1, 1,  0,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  0, 1, 0);
      add(0, 0, 4, 1, 1,  1,  8, 1, 0);
      add(0, 0, 4, 1, 1,  1, 16, 1, 0);
      add(0, 0, 4, 1, 1,  1, 24, 1, 0);
      add(0, 0, 0, 1, 1,  0, 32, 0, 1);
      add(0, 0, 0, 1, 1,  0, 32, 0, 0);

      @(posedge ui_clk);
      for (int i = 0; i < vq.size(); i++) begin
         #2;
         rst           = vq[i].rst;
         wr_start      = vq[i].start;
         fifo_rd_count = vq[i].cnt;
         app_rdy       = vq[i].rdy;
         app_wdf_rdy   = vq[i].wrdy;
         fifo_rd_data  = {8{32'hC3A5_0000 ^ 32'(i)}};
         #3;
         chk("app_en",   i, 64'(app_en),   64'(vq[i].en));
         chk("app_addr", i, 64'(app_addr), 64'(vq[i].addr));
         chk("wr_busy",  i, 64'(wr_busy),  64'(vq[i].busy));
         chk("wr_done",  i, 64'(wr_done),  64'(vq[i].done));
         chk_common(i, vq[i].en);
         @(posedge ui_clk);
      end

      // T5: burst from address 32 under irregular ready; the beat after 40 must go to 0
      #2;
      wr_start      = 1'b1;
      fifo_rd_count = CNT_W'(4);
      app_rdy       = 1'b1;
      app_wdf_rdy   = 1'b1;
      @(posedge ui_clk);
      #2;
      wr_start = 1'b0;
      #3;
      chk("t5_wait_en",   100, 64'(app_en),  64'd0);
      chk("t5_wait_busy", 100, 64'(wr_busy), 64'd1);
      @(posedge ui_clk);
      exp_addr = ADDR_W'(32);
      fires    = 0;
      saw_wrap = 1'b0;
      for (int c = 0; c < 60 && fires < 4; c++) begin
         #2;
         if (c % 3 == 2) begin
            app_rdy     = 1'b1;
            app_wdf_rdy = 1'b1;
         end else begin
            app_rdy     = 1'($urandom_range(0, 1));
            app_wdf_rdy = 1'($urandom_range(0, 1));
         end
         fifo_rd_data = {8{$urandom}};
         exp_fire     = app_rdy & app_wdf_rdy;
         #3;
         chk("t5_app_en",   200 + c, 64'(app_en),   64'(exp_fire));
         chk("t5_app_addr", 200 + c, 64'(app_addr), 64'(exp_addr));
         chk("t5_wr_busy",  200 + c, 64'(wr_busy),  64'd1);
         chk_common(200 + c, exp_fire);
         if (exp_fire) begin
            if (exp_addr == ADDR_MAX) begin
               exp_addr = '0;
               saw_wrap = 1'b1;
            end else begin
               exp_addr = exp_addr + ADDR_W'(ADDR_STEP);
            end
            fires++;
         end
         @(posedge ui_clk);
      end
      chk("t5_beats_issued", 300, 64'(fires),    64'd4);
      chk("t5_wrapped",      300, 64'(saw_wrap), 64'd1);
      #5;
      chk("t5_done",      301, 64'(wr_done),  64'd1);
      chk("t5_done_en",   301, 64'(app_en),   64'd0);
      chk("t5_done_addr", 301, 64'(app_addr), 64'd16);
      @(posedge ui_clk);
      #5;
      chk("t5_idle_done", 302, 64'(wr_done), 64'd0);
      chk("t5_idle_busy", 302, 64'(wr_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
